// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: decoder op codes,
// FSM states, datapath select encodings and op-class helpers.
package ctrl_pkg;

  typedef enum logic [5:0] {
    OP_ADDI  = 6'd0,  OP_SLTI  = 6'd1,  OP_SLTIU = 6'd2,  OP_XORI  = 6'd3,
    OP_ORI   = 6'd4,  OP_ANDI  = 6'd5,  OP_SLLI  = 6'd6,  OP_SRLI  = 6'd7,
    OP_SRAI  = 6'd8,  OP_ADD   = 6'd9,  OP_SUB   = 6'd10, OP_SLL   = 6'd11,
    OP_SLT   = 6'd12, OP_SLTU  = 6'd13, OP_XOR   = 6'd14, OP_SRL   = 6'd15,
    OP_SRA   = 6'd16, OP_OR    = 6'd17, OP_AND   = 6'd18, OP_LB    = 6'd19,
    OP_LH    = 6'd20, OP_LW    = 6'd21, OP_LBU   = 6'd22, OP_LHU   = 6'd23,
    OP_SB    = 6'd24, OP_SH    = 6'd25, OP_SW    = 6'd26, OP_LUI   = 6'd27,
    OP_AUIPC = 6'd28, OP_JAL   = 6'd29, OP_JALR  = 6'd30, OP_BEQ   = 6'd31,
    OP_BNE   = 6'd32, OP_BLT   = 6'd33, OP_BGE   = 6'd34, OP_BLTU  = 6'd35,
    OP_BGEU  = 6'd36
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } dmem_size_e;

  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_unsigned_load(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic dmem_size_e mem_size(input logic [5:0] op);
    dmem_size_e size;
    case (op)
      OP_LB, OP_LBU, OP_SB: size = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: size = SIZE_HALF;
      default:              size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-handshake watchdog: counts stalled request cycles and flags the cycle
// in which the stall would reach LIMIT. LIMIT of 0 never expires.
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] count;

  // The stall counted this cycle is the LIMIT-th one when count already holds LIMIT-1.
  assign expired = (LIMIT != 0) && enable && (count == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback,
// drives datapath enables and selects, counts retirements, times out memory stalls.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             dec_we,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [1:0]       dmem_size,
  output logic             dmem_unsigned,
  output logic             mdr_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  state_e           state;
  state_e           next_state;
  logic             waiting;
  logic             timeout;
  logic             state_change;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // A stall is a request cycle in FETCH or MEM whose ready has not arrived.
  assign waiting      = !reset && (((state == S_FETCH) && !imem_ready) ||
                                   ((state == S_MEM)   && !dmem_ready));
  assign state_change = (next_state != state);

  wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_change),
    .enable  (waiting),
    .expired (timeout)
  );

  always_comb begin
    next_state    = state;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_size     = SIZE_BYTE;
    dmem_unsigned = 1'b0;
    mdr_we        = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    illegal       = 1'b0;
    bus_err       = 1'b0;
    retire        = 1'b0;

    if (!reset) begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            imem_req   = 1'b1;
            ir_we      = 1'b1;
            next_state = S_DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
          end else begin
            imem_req = 1'b1;
          end
        end

        S_DECODE: begin
          if ((op == OP_ADDI) && !dec_we) begin
            illegal    = 1'b1;
            pc_we      = 1'b1;
            pc_sel     = PC_PLUS4;
            next_state = S_FETCH;
          end else begin
            next_state = S_EXEC;
          end
        end

        S_EXEC: begin
          if (is_branch(op)) begin
            pc_we      = 1'b1;
            pc_sel     = br_taken ? PC_IMM : PC_PLUS4;
            retire     = 1'b1;
            next_state = S_FETCH;
          end else if (is_load(op) || is_store(op)) begin
            next_state = S_MEM;
          end else begin
            next_state = S_WB;
          end
        end

        // Access attributes are only driven while the request is up.
        S_MEM: begin
          if (dmem_ready || !timeout) begin
            dmem_req      = 1'b1;
            dmem_we       = is_store(op);
            dmem_size     = mem_size(op);
            dmem_unsigned = is_unsigned_load(op);
          end
          if (dmem_ready) begin
            if (is_store(op)) begin
              pc_we      = 1'b1;
              pc_sel     = PC_PLUS4;
              retire     = 1'b1;
              next_state = S_FETCH;
            end else begin
              mdr_we     = 1'b1;
              next_state = S_WB;
            end
          end else if (timeout) begin
            bus_err    = 1'b1;
            pc_we      = 1'b1;
            pc_sel     = PC_PLUS4;
            next_state = S_FETCH;
          end
        end

        S_WB: begin
          rf_we = dec_we;
          if (is_load(op)) begin
            wb_sel = WB_MEM;
          end else if ((op == OP_JAL) || (op == OP_JALR)) begin
            wb_sel = WB_PC4;
          end
          pc_we = 1'b1;
          if (op == OP_JAL) begin
            pc_sel = PC_IMM;
          end else if (op == OP_JALR) begin
            pc_sel = PC_ALU;
          end
          retire     = 1'b1;
          next_state = S_FETCH;
        end

        default: begin
          next_state = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret   = reset ? '0 : instret_q;
  assign state_dbg = reset ? 3'd0 : state;

endmodule
